// File: rtl/ram_av_bridge.sv
// ram_av_bridge: Avalon-MM slave front end for a byte-banked, combinational-read RAM.
// Accepts single and burst reads/writes, generates burst addresses internally,
// registers read data (latency 1) and stalls the bus while a read burst streams.
//
// Optional feature macro: RAM_AV_BRIDGE_OUTREG_EN
//   defined   -> extra output register on readdata/readdatavalid (read latency 2)
//   undefined -> read latency 1
//
// Handshake: a command is accepted in any cycle where avs_waitrequest is 0 and
// avs_read or avs_write is high. Within a write burst, each cycle with
// avs_write=1 is a beat; the bridge never stalls writes. Each read beat produces
// exactly one avs_readdatavalid pulse, in issue order, with no gaps inside a burst.
module ram_av_bridge #(
  parameter int a_width  = 7,
  parameter int bc_width = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [a_width-1:0]  avs_address,
  input  logic                avs_read,
  input  logic                avs_write,
  input  logic [31:0]         avs_writedata,
  input  logic [3:0]          avs_byteenable,
  input  logic [bc_width-1:0] avs_burstcount,
  output logic                avs_waitrequest,
  output logic [31:0]         avs_readdata,
  output logic                avs_readdatavalid,
  output logic [a_width-1:0]  ram_addr,
  output logic [3:0]          ram_we,
  output logic [31:0]         ram_wd,
  input  logic [31:0]         ram_rd
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WBURST = 2'd1,
    RBURST = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [a_width-1:0]  addr_q, addr_d;
  logic [bc_width-1:0] cnt_q, cnt_d;
  logic                wr_beat;
  logic                rd_issue;
  logic                rd_busy;
  logic                multi_beat;

  logic                rd_valid_q;
  logic [31:0]         rd_data_q;

  // Burstcount 0 and 1 both mean a single beat; only >1 enters a burst state.
  assign multi_beat = (avs_burstcount > bc_width'(1));

  // FSM state and burst address/counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, burst bookkeeping and RAM address mux.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    wr_beat  = 1'b0;
    rd_issue = 1'b0;
    rd_busy  = 1'b0;
    ram_addr = addr_q;
    case (state_q)
      IDLE: begin
        ram_addr = avs_address;
        if (avs_write) begin
          // A write wins over a simultaneous read; the read is dropped.
          wr_beat = 1'b1;
          if (multi_beat) begin
            state_d = WBURST;
            addr_d  = avs_address + a_width'(1);
            cnt_d   = avs_burstcount - bc_width'(1);
          end
        end else if (avs_read) begin
          rd_issue = 1'b1;
          if (multi_beat) begin
            state_d = RBURST;
            addr_d  = avs_address + a_width'(1);
            cnt_d   = avs_burstcount - bc_width'(1);
          end
        end
      end
      WBURST: begin
        // Cycles without avs_write are master stalls and leave state untouched.
        if (avs_write) begin
          wr_beat = 1'b1;
          addr_d  = addr_q + a_width'(1);
          cnt_d   = cnt_q - bc_width'(1);
          if (cnt_q <= bc_width'(1)) state_d = IDLE;
        end
      end
      RBURST: begin
        rd_issue = 1'b1;
        rd_busy  = 1'b1;
        addr_d   = addr_q + a_width'(1);
        cnt_d    = cnt_q - bc_width'(1);
        if (cnt_q <= bc_width'(1)) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Reset forces a stall and blocks writes even if the master keeps driving.
  assign avs_waitrequest = rst | rd_busy;
  assign ram_we          = (wr_beat && !rst) ? avs_byteenable : 4'b0000;
  assign ram_wd          = avs_writedata;

  // First read stage: capture the combinational RAM output for each issued beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_issue;
      if (rd_issue) rd_data_q <= ram_rd;
    end
  end

`ifdef RAM_AV_BRIDGE_OUTREG_EN
  logic        out_valid_q;
  logic [31:0] out_data_q;

  // Second read stage: data only moves on a valid beat, so readdata holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= rd_valid_q;
      if (rd_valid_q) out_data_q <= rd_data_q;
    end
  end

  assign avs_readdatavalid = out_valid_q;
  assign avs_readdata      = out_data_q;
`else
  assign avs_readdatavalid = rd_valid_q;
  assign avs_readdata      = rd_data_q;
`endif

endmodule

// File: tb/tb_ram_av_bridge.sv
// tb_ram_av_bridge: self-checking bench for ram_av_bridge with a behavioural
// byte-banked RAM attached to the RAM port and a word-array reference memory.
module tb_ram_av_bridge;

`ifdef RAM_AV_BRIDGE_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic [6:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [3:0]  avs_byteenable = '0;
  logic [3:0]  avs_burstcount = '0;
  logic        avs_waitrequest;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic [6:0]  ram_addr;
  logic [3:0]  ram_we;
  logic [31:0] ram_wd;
  logic [31:0] ram_rd;

  ram_av_bridge #(.a_width(7), .bc_width(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_byteenable    (avs_byteenable),
    .avs_burstcount    (avs_burstcount),
    .avs_waitrequest   (avs_waitrequest),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .ram_addr          (ram_addr),
    .ram_we            (ram_we),
    .ram_wd            (ram_wd),
    .ram_rd            (ram_rd)
  );

  // Attached RAM: four byte banks, write on clock edge, combinational read.
  logic [31:0] mem [0:127];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wd[8*b +: 8];
  end
  assign ram_rd = mem[ram_addr];

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] ref_mem [0:127];
  logic [63:0] exp_q[$];          // {expected valid cycle, expected data}
  logic [31:0] last_data = '0;
  int          busy_until = 0;    // waitrequest expected high while cyc < busy_until
  int          nchecks = 0;
  int          nerr = 0;
  int          vcount = 0;

  logic [31:0] wd_arr [0:15];
  logic [3:0]  be_arr [0:15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Read-data monitor: every valid must match the next expected beat and cycle.
  always @(negedge clk) begin
    if (rst) begin
      last_data = '0;
    end else if (avs_readdatavalid) begin
      vcount++;
      if (exp_q.size() == 0) begin
        check("rd_unexpected_valid", 1, 0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("rd_data", avs_readdata, e[31:0]);
        check("rd_cycle", cyc, e[63:32]);
        last_data = e[31:0];
      end
    end else begin
      check("rd_hold", avs_readdata, last_data);
      if (exp_q.size() > 0 && exp_q[0][63:32] <= 32'(cyc)) begin
        check("rd_missing_valid", 0, 1);
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Waits (bounded) for the cycle where the current command is accepted;
  // returns at that cycle's falling edge.
  task automatic wait_accept(output int acc);
    int k = 0;
    forever begin
      @(negedge clk);
      check("waitrequest", avs_waitrequest, (cyc < busy_until));
      if (!avs_waitrequest) break;
      k++;
      if (k > 40) begin
        check("accept_timeout", 1, 0);
        break;
      end
      @(posedge clk); #1;
    end
    acc = cyc;
  endtask

  task automatic write_burst(input int a, input int bc, input int stall_beat, input int stall_len);
    int n;
    int acc;
    n = (bc == 0) ? 1 : bc;
    for (int i = 0; i < n; i++) begin
      if (i > 0 && i == stall_beat) begin
        for (int s = 0; s < stall_len; s++) begin
          avs_write = 1'b0;
          avs_read = 1'($urandom_range(0, 1));
          avs_writedata = $urandom;
          @(negedge clk);
          check("stall_we", ram_we, 0);
          check("stall_waitreq", avs_waitrequest, 0);
          @(posedge clk); #1;
        end
      end
      avs_write      = 1'b1;
      avs_read       = 1'($urandom_range(0, 1));
      avs_address    = (i == 0) ? 7'(a) : 7'($urandom);
      avs_burstcount = 4'(bc);
      avs_writedata  = wd_arr[i];
      avs_byteenable = be_arr[i];
      if (i == 0) wait_accept(acc);
      else begin
        @(negedge clk);
        check("wr_waitreq", avs_waitrequest, 0);
      end
      check("wr_we", ram_we, be_arr[i]);
      check("wr_addr", ram_addr, (a + i) & 127);
      for (int b = 0; b < 4; b++)
        if (be_arr[i][b]) ref_mem[(a + i) & 127][8*b +: 8] = wd_arr[i][8*b +: 8];
      @(posedge clk); #1;
    end
    avs_write = 1'b0;
    avs_read  = 1'b0;
  endtask

  task automatic issue_read(input int a, input int bc, input bit ovr, input logic [31:0] ovr_d,
                            output int acc);
    int n;
    n = (bc == 0) ? 1 : bc;
    avs_read       = 1'b1;
    avs_write      = 1'b0;
    avs_address    = 7'(a);
    avs_burstcount = 4'(bc);
    wait_accept(acc);
    for (int i = 0; i < n; i++)
      exp_q.push_back({32'(acc + i + LAT), (ovr && i == 0) ? ovr_d : ref_mem[(a + i) & 127]});
    busy_until = acc + n;
    @(posedge clk); #1;
    avs_read    = 1'b0;
    avs_address = 7'($urandom);
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() > 0 && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          wr;
    int          addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [0:7];
  int   acc, acc2, v0, k;

  initial begin
    tbl[0] = '{1'b1, 5, 32'hDEADBEEF, 4'hF, 32'h0};
    tbl[1] = '{1'b0, 5, 32'h0,        4'h0, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 3, 32'h11223344, 4'hF, 32'h0};
    tbl[3] = '{1'b1, 3, 32'hAABBCCDD, 4'h5, 32'h0};
    tbl[4] = '{1'b0, 3, 32'h0,        4'h0, 32'h11BB33DD};
    tbl[5] = '{1'b1, 7, 32'hCAFEF00D, 4'hF, 32'h0};
    tbl[6] = '{1'b0, 7, 32'h0,        4'h0, 32'hCAFEF00D};
    tbl[7] = '{1'b0, 5, 32'h0,        4'h0, 32'hDEADBEEF};

    // Reset: master drives a write and a read, neither may take effect.
    rst = 1'b1;
    avs_write = 1'b1; avs_read = 1'b1; avs_byteenable = 4'hF; avs_burstcount = 4'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_waitreq", avs_waitrequest, 1);
    check("rst_valid", avs_readdatavalid, 0);
    check("rst_rdata", avs_readdata, 0);
    check("rst_we", ram_we, 0);
    avs_write = 1'b0; avs_read = 1'b0;
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Fill the whole memory through 15-beat write bursts (last one wraps).
    for (int j = 0; j < 9; j++) begin
      for (int i = 0; i < 15; i++) begin
        wd_arr[i] = $urandom;
        be_arr[i] = 4'hF;
      end
      write_burst((j * 15) & 127, 15, 16, 0);
    end

    // Directed single accesses, back-to-back where a read follows a write.
    for (int t = 0; t < 8; t++) begin
      if (tbl[t].wr) begin
        wd_arr[0] = tbl[t].data;
        be_arr[0] = tbl[t].be;
        write_burst(tbl[t].addr, 1, 16, 0);
      end else begin
        issue_read(tbl[t].addr, 1, 1'b1, tbl[t].exp, acc);
      end
    end
    drain();

    // Write burst of 4 at 10 with a two-cycle stall after beat 2.
    for (int i = 0; i < 4; i++) begin
      wd_arr[i] = 32'(i + 1);
      be_arr[i] = 4'hF;
    end
    write_burst(10, 4, 2, 2);
    for (int i = 0; i < 4; i++) issue_read(10 + i, 1, 1'b1, 32'(i + 1), acc);
    drain();

    // Read burst wrapping 127 -> 0, with the next read presented one cycle later.
    wd_arr[0] = 32'hA0A0A0A0; wd_arr[1] = 32'hB1B1B1B1;
    wd_arr[2] = 32'hC2C2C2C2; wd_arr[3] = 32'hD3D3D3D3;
    for (int i = 0; i < 4; i++) be_arr[i] = 4'hF;
    write_burst(126, 4, 16, 0);
    issue_read(126, 4, 1'b1, 32'hA0A0A0A0, acc);
    issue_read(50, 1, 1'b0, 32'h0, acc2);
    check("rd_next_accept_cycle", acc2, acc + 4);
    drain();

    // Reset in the middle of an 8-beat read burst.
    v0 = vcount;
    issue_read(20, 8, 1'b0, 32'h0, acc);
    k = 0;
    while (vcount - v0 < 3 && k < 60) begin
      @(negedge clk); #1;
      k++;
    end
    check("rst_burst_valids_seen", vcount - v0, 3);
    rst = 1'b1;
    #1;
    check("rst_mid_valid", avs_readdatavalid, 0);
    check("rst_mid_rdata", avs_readdata, 0);
    check("rst_mid_waitreq", avs_waitrequest, 1);
    check("rst_mid_we", ram_we, 0);
    exp_q.delete();
    busy_until = 0;
    @(posedge clk);
    @(negedge clk);
    check("rst_hold_valid", avs_readdatavalid, 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    issue_read(20, 1, 1'b0, 32'h0, acc);
    drain();

    // Randomized traffic against the reference memory.
    for (int t = 0; t < 80; t++) begin
      int a, bc;
      a  = $urandom_range(0, 127);
      bc = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) begin
          wd_arr[i] = $urandom;
          be_arr[i] = 4'($urandom);
        end
        write_burst(a, bc, $urandom_range(1, 16), $urandom_range(1, 3));
      end else begin
        issue_read(a, bc, 1'b0, 32'h0, acc);
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

  // Global time bound.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", nchecks, nerr);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram_av_bridge.md
# ram_av_bridge

Avalon-MM slave front end for the byte-banked `ram` block. It accepts single and burst reads and writes from the interconnect and drives the RAM's `addr`/`we`/`wd` port, which reads combinationally. It registers returned read data with a fixed latency, generates burst addresses internally and stalls the bus with `waitrequest` while a read burst is streaming. It sits between the Avalon interconnect and one `ram` instance, with matching `a_width`.

## Interface
- `a_width`, 7: RAM word-address width; must equal the attached `ram` instance.
- `bc_width`, 4: burstcount width; maximum burst is 2^bc_width − 1 beats.
- `clk` in 1: clock; all state on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `avs_address` in a_width: word address (word-addressed slave).
- `avs_read` in 1: read command.
- `avs_write` in 1: write command / write beat.
- `avs_writedata` in 32: write data.
- `avs_byteenable` in 4: byte lanes for write; bit i → RAM bank i.
- `avs_burstcount` in bc_width: beats in burst; 0 is treated as 1.
- `avs_waitrequest` out 1: slave stall.
- `avs_readdata` out 32: read data.
- `avs_readdatavalid` out 1: `avs_readdata` valid this cycle.
- `ram_addr` out a_width: to `ram.addr`.
- `ram_we` out 4: to `ram.we`.
- `ram_wd` out 32: to `ram.wd`.
- `ram_rd` in 32: from `ram.rd`, combinational read.

## Operation
- FSM states: IDLE, WBURST, RBURST. Internal registers:
  - `addr_q` (a_width): next burst address.
  - `cnt_q` (bc_width): beats remaining.
- IDLE:
  - `avs_waitrequest`=0. `ram_addr`=`avs_address` (combinational mux).
  - If `avs_write`: `ram_we`=`avs_byteenable`, `ram_wd`=`avs_writedata`. The beat is written at the next edge.
  - If `avs_write` and n>1: go to WBURST with `addr_q`=`avs_address`+1, `cnt_q`=n−1.
  - Else if `avs_read`: read beat issued, `ram_rd` captured at the next edge. If n>1: go to RBURST with `addr_q`=`avs_address`+1, `cnt_q`=n−1.
  - `avs_read` and `avs_write` both high (protocol violation): write wins, read dropped.
- WBURST:
  - `avs_waitrequest`=0. `ram_addr`=`addr_q`; `avs_address` is ignored.
  - Cycles with `avs_write`=0 are stalls: `ram_we`=0, no state change.
  - Each beat with `avs_write`=1 writes with its own `avs_byteenable`, increments `addr_q` and decrements `cnt_q`.
  - The beat taken when `cnt_q`==1 returns the FSM to IDLE.
  - `avs_read` is ignored in WBURST.
- RBURST:
  - `avs_waitrequest`=1. `ram_addr`=`addr_q`; one beat is issued every cycle.
  - `addr_q` increments and `cnt_q` decrements each cycle. The cycle with `cnt_q`==1 is the last; the FSM returns to IDLE after it.
- Whenever no write beat is accepted, `ram_we`=0. `ram_wd` = `avs_writedata` at all times.
- `addr_q` wraps modulo 2^a_width. A burst crossing the top address continues at 0.
- Read-after-write: a write at edge k is visible to a read issued in the cycle after edge k.

## Timing
- Reset values, held while `rst`=1:
  - `avs_waitrequest`=1, `avs_readdatavalid`=0, `avs_readdata`=0, `ram_we`=0.
  - FSM in IDLE, `addr_q`=0, `cnt_q`=0.
- Read latency is 1 cycle: a beat issued in cycle c gives `avs_readdatavalid`=1 in cycle c+1.
- Read burst of n accepted in cycle 0:
  - Valid in cycles 1..n, with no gaps.
  - `avs_waitrequest`=1 in cycles 1..n−1.
  - The next command can be accepted in cycle n.
- Write burst of n completes with no wait states; the bridge never back-pressures writes.
- `avs_readdata` holds its last value when not valid.
- Reset mid-burst aborts the burst immediately. No further valid beats and no RAM writes occur.

## Configuration
- `RAM_AV_BRIDGE_OUTREG_EN` defined:
  - A second register stage is added on `avs_readdata`/`avs_readdatavalid`; read latency becomes 2.
  - Burst valids occur in cycles 2..n+1, and the next command is still accepted in cycle n.
  - The extra stage also resets to 0.
- `RAM_AV_BRIDGE_OUTREG_EN` undefined: read latency is 1, as specified above.

## Test plan
- Single write then read: write addr 5, data 0xDEADBEEF, byteenable 0xF, then read addr 5 → readdatavalid one cycle after the read is accepted, readdata 0xDEADBEEF.
- Byte enables: preload addr 3 with 0x11223344, write 0xAABBCCDD with byteenable 0x5, read addr 3 → 0x11BB33DD.
- Write burst with stall: burstcount 4 at addr 10, data 1..4, `avs_write` dropped for 2 cycles after beat 2; then read addrs 10..13 singly → 1,2,3,4; `ram_we`=0 during the stall cycles.
- Read burst with wrap: a_width 7, preload 126,127,0,1 with A,B,C,D, read burstcount 4 at 126 → valids in cycles 1..4 with A,B,C,D; waitrequest high cycles 1..3; a read presented in cycle 1 is accepted only in cycle 4.
- Reset mid read burst: burstcount 8, assert `rst` after 3 valids → valid and readdata are 0 immediately and waitrequest is 1; after release, a single read returns correct data with latency 1.
- Back-to-back accesses: a write at addr 7 followed by a read of addr 7 in the next cycle → the new data is returned; repeated with `RAM_AV_BRIDGE_OUTREG_EN` defined → latency 2.
